// File: rtl/sample_seq_pkg.sv
// rtl/sample_seq_pkg.sv - shared sizes, FSM states and subsample step decode for the sample sequencer
package sample_seq_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1) << RADIX;

  typedef enum logic {WAIT, TEST} state_t;

  // Any pattern that is not exactly one-hot falls back to whole-pixel pitch.
  function automatic logic signed [SIGFIG-1:0] decode_step(input logic [3:0] sub);
    case (sub)
      4'b0100: decode_step = ONE >> 1;
      4'b0010: decode_step = ONE >> 2;
      4'b0001: decode_step = ONE >> 3;
      default: decode_step = ONE;
    endcase
  endfunction
endpackage

// File: rtl/sample_box_walker.sv
// rtl/sample_box_walker.sv - raster-order sample walk over a latched bounding box
module sample_box_walker
  import sample_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     advance,
  input  logic signed [SIGFIG-1:0] ll_x,
  input  logic signed [SIGFIG-1:0] ll_y,
  input  logic signed [SIGFIG-1:0] ur_x,
  input  logic signed [SIGFIG-1:0] ur_y,
  input  logic signed [SIGFIG-1:0] step,
  output logic signed [SIGFIG-1:0] sample_x,
  output logic signed [SIGFIG-1:0] sample_y,
  output logic                     last
);
  logic signed [SIGFIG-1:0] box_llx, box_urx, box_ury, step_q;
  logic signed [SIGFIG:0]   nx, ny;
  logic                     x_ok, y_ok;

  // One extra bit keeps the stepped coordinate from wrapping past the box edge.
  always_comb begin
    nx   = (SIGFIG+1)'(sample_x) + (SIGFIG+1)'(step_q);
    ny   = (SIGFIG+1)'(sample_y) + (SIGFIG+1)'(step_q);
    x_ok = nx <= (SIGFIG+1)'(box_urx);
    y_ok = ny <= (SIGFIG+1)'(box_ury);
    last = !x_ok && !y_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      box_llx  <= '0;
      box_urx  <= '0;
      box_ury  <= '0;
      step_q   <= '0;
      sample_x <= '0;
      sample_y <= '0;
    end else if (load) begin
      box_llx  <= ll_x;
      box_urx  <= ur_x;
      box_ury  <= ur_y;
      step_q   <= step;
      sample_x <= ll_x;
      sample_y <= ll_y;
    end else if (advance && !last) begin
      if (x_ok) begin
        sample_x <= nx[SIGFIG-1:0];
      end else begin
        sample_x <= box_llx;
        sample_y <= ny[SIGFIG-1:0];
      end
    end
  end
endmodule

// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - accepts a triangle and bbox, streams one sample per cycle to sample test
module sample_sequencer
  import sample_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R14S [VERTS-1:0][AXIS-1:0],
  input  logic        [SIGFIG-1:0] color_R14U [COLORS-1:0],
  input  logic signed [SIGFIG-1:0] box_R14S [1:0][1:0],
  input  logic                     validTri_R14H,
  input  logic [3:0]               subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R16S [VERTS-1:0][AXIS-1:0],
  output logic        [SIGFIG-1:0] color_R16U [COLORS-1:0],
  output logic signed [SIGFIG-1:0] sample_R16S [1:0],
  output logic                     validSamp_R16H
);
  state_t state, state_nxt;
  logic   last, box_ok, accept, load;

  // Halt opens during the final sample so the next triangle follows with no bubble.
  always_comb begin
    halt_RnnnnL    = (state == WAIT) || (state == TEST && last);
    validSamp_R16H = (state == TEST);
    box_ok         = (box_R14S[0][0] <= box_R14S[1][0]) && (box_R14S[0][1] <= box_R14S[1][1]);
    accept         = validTri_R14H && halt_RnnnnL;
    load           = accept && box_ok;
    state_nxt      = state;
    if (load) begin
      state_nxt = TEST;
    end else if (state == TEST && last) begin
      state_nxt = WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT;
      tri_R16S   <= '{default: '0};
      color_R16U <= '{default: '0};
    end else begin
      state <= state_nxt;
      if (load) begin
        tri_R16S   <= tri_R14S;
        color_R16U <= color_R14U;
      end
    end
  end

  sample_box_walker u_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (state == TEST),
    .ll_x     (box_R14S[0][0]),
    .ll_y     (box_R14S[0][1]),
    .ur_x     (box_R14S[1][0]),
    .ur_y     (box_R14S[1][1]),
    .step     (decode_step(subSample_RnnnnU)),
    .sample_x (sample_R16S[0]),
    .sample_y (sample_R16S[1]),
    .last     (last)
  );
endmodule

// File: tb/tb_sample_sequencer.sv
// tb/tb_sample_sequencer.sv - randomized scoreboard bench for sample_sequencer
module tb_sample_sequencer;
  import sample_seq_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_R14S [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] color_R14U [COLORS-1:0];
  logic signed [SIGFIG-1:0] box_R14S [1:0][1:0];
  logic                     validTri_R14H;
  logic [3:0]               subSample_RnnnnU;
  logic                     halt_RnnnnL;
  logic signed [SIGFIG-1:0] tri_R16S [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] color_R16U [COLORS-1:0];
  logic signed [SIGFIG-1:0] sample_R16S [1:0];
  logic                     validSamp_R16H;

  sample_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .box_R14S         (box_R14S),
    .validTri_R14H    (validTri_R14H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R16S         (tri_R16S),
    .color_R16U       (color_R16U),
    .sample_R16S      (sample_R16S),
    .validSamp_R16H   (validSamp_R16H)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int qx[$];
  int qy[$];
  logic [VERTS*AXIS*SIGFIG-1:0] exp_tri = '0;
  logic [COLORS*SIGFIG-1:0]     exp_col = '0;
  bit                           exp_zero = 1'b1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_step(input logic [3:0] s);
    case (s)
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  function automatic logic [VERTS*AXIS*SIGFIG-1:0] pack_tri(input logic signed [SIGFIG-1:0] t [VERTS-1:0][AXIS-1:0]);
    logic [VERTS*AXIS*SIGFIG-1:0] r;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        r[(v*AXIS+a)*SIGFIG +: SIGFIG] = t[v][a];
    return r;
  endfunction

  function automatic logic [COLORS*SIGFIG-1:0] pack_col(input logic [SIGFIG-1:0] c [COLORS-1:0]);
    logic [COLORS*SIGFIG-1:0] r;
    for (int i = 0; i < COLORS; i++) r[i*SIGFIG +: SIGFIG] = c[i];
    return r;
  endfunction

  // Sets this cycle's inputs and predicts what the next edge does with them.
  task automatic drive(input bit v, input bit r, output bit acc);
    int llx, lly, urx, ury, st;
    rst = r;
    validTri_R14H = v;
    acc = 1'b0;
    llx = int'(box_R14S[0][0]);
    lly = int'(box_R14S[0][1]);
    urx = int'(box_R14S[1][0]);
    ury = int'(box_R14S[1][1]);
    if (r) begin
      qx.delete();
      qy.delete();
      exp_tri = '0;
      exp_col = '0;
      exp_zero = 1'b1;
    end else if (v && qx.size() == 0) begin
      acc = 1'b1;
      if (llx <= urx && lly <= ury) begin
        st = model_step(subSample_RnnnnU);
        for (int y = lly; y <= ury; y += st)
          for (int x = llx; x <= urx; x += st) begin
            qx.push_back(x);
            qy.push_back(y);
          end
        exp_tri = pack_tri(tri_R14S);
        exp_col = pack_col(color_R14U);
        exp_zero = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (validSamp_R16H) vcount++;
    check("valid", validSamp_R16H, qx.size() > 0);
    check("halt", halt_RnnnnL, qx.size() <= 1);
    check("tri", pack_tri(tri_R16S), exp_tri);
    check("color", pack_col(color_R16U), exp_col);
    if (qx.size() > 0) begin
      check("sample_x", sample_R16S[0], qx.pop_front());
      check("sample_y", sample_R16S[1], qy.pop_front());
    end else if (exp_zero) begin
      check("sample_x_rst", sample_R16S[0], 0);
      check("sample_y_rst", sample_R16S[1], 0);
    end
  endtask

  task automatic send(input int llx, input int lly, input int urx, input int ury,
                      input logic [3:0] sub, input bit jitter);
    bit a;
    int n = 0;
    box_R14S[0][0] = SIGFIG'(llx);
    box_R14S[0][1] = SIGFIG'(lly);
    box_R14S[1][0] = SIGFIG'(urx);
    box_R14S[1][1] = SIGFIG'(ury);
    subSample_RnnnnU = sub;
    for (int v = 0; v < VERTS; v++)
      for (int ax = 0; ax < AXIS; ax++) tri_R14S[v][ax] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++) color_R14U[c] = SIGFIG'($urandom);
    do begin
      if (jitter) subSample_RnnnnU = 4'($urandom_range(0, 15));
      drive(1'b1, 1'b0, a);
      tick();
      n++;
    end while (!a && n < 3000);
    if (!a) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit a;
    int n = 0;
    while (qx.size() > 0 && n < 3000) begin
      drive(1'b0, 1'b0, a);
      tick();
      n++;
    end
    if (qx.size() > 0) check("idle_timeout", 0, 1);
    drive(1'b0, 1'b0, a);
    tick();
  endtask

  initial begin
    bit a;
    int llx, lly;
    box_R14S = '{default: '0};
    tri_R14S = '{default: '0};
    color_R14U = '{default: '0};
    subSample_RnnnnU = 4'b1000;
    validTri_R14H = 1'b1;
    rst = 1'b1;

    repeat (2) begin
      drive(1'b1, 1'b1, a);
      tick();
    end

    vcount = 0;
    send(0, 0, 2048, 1024, 4'b1000, 1'b0);
    wait_idle();
    check("count_pitch1", vcount, 6);

    vcount = 0;
    send(0, 0, 2048, 1024, 4'b0100, 1'b0);
    subSample_RnnnnU = 4'b1000;
    wait_idle();
    check("count_pitch_half", vcount, 15);

    vcount = 0;
    send(0, 0, 2048, 1024, 4'b1000, 1'b0);
    send(-1024, -1024, 0, -1024, 4'b1000, 1'b0);
    wait_idle();
    check("count_b2b", vcount, 8);

    vcount = 0;
    send(-3072, 5120, -3072, 5120, 4'b1000, 1'b0);
    wait_idle();
    check("count_degenerate", vcount, 1);

    vcount = 0;
    send(2048, 0, 1024, 0, 4'b1000, 1'b0);
    wait_idle();
    check("count_inverted", vcount, 0);

    vcount = 0;
    send(0, 0, 2048, 1024, 4'b1000, 1'b0);
    repeat (2) begin
      drive(1'b0, 1'b0, a);
      tick();
    end
    drive(1'b0, 1'b1, a);
    tick();
    send(0, 0, 1024, 1024, 4'b1000, 1'b0);
    wait_idle();
    check("count_mid_reset", vcount, 7);

    for (int i = 0; i < 150; i++) begin
      llx = $urandom_range(0, 8192) - 4096;
      lly = $urandom_range(0, 8192) - 4096;
      send(llx, lly, llx + $urandom_range(0, 1792) - 256, lly + $urandom_range(0, 1792) - 256,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) wait_idle();
      if ($urandom_range(0, 19) == 0) begin
        drive(1'b0, 1'b1, a);
        tick();
      end
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
